pwm_multi_core: RTL and testbench
=================================

// Module: pwm_multi_core
// PURPOSE
//  Multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs.
//  Adds centre-aligned mode, per-channel polarity and double-buffered duty/period updates.
//  Updates take effect only at period boundaries, so outputs never glitch.
//  Sits between the bus-facing control registers and the board pins.
// PARAMETERS
//  WIDTH     9  counter, period and duty width in bits
//  CHANNELS  4  number of independent PWM outputs
// PORTS
//  clk           in   1               clock, rising edge
//  reset         in   1               asynchronous, active-low
//  enable        in   1               1 = run; 0 = counter held, outputs inactive
//  update_req    in   1               1-cycle strobe: capture period/duty/centre into pending shadow
//  period        in   WIDTH           period value P
//  duty          in   CHANNELS*WIDTH  per-channel duty D[i]; channel i at [i*WIDTH +: WIDTH]
//  centre        in   1               0 = edge-aligned, 1 = centre-aligned
//  polarity      in   CHANNELS        per channel: 1 = active-high, 0 = inverted
//  out           out  CHANNELS        registered PWM outputs
//  period_end    out  1               registered 1-cycle pulse at each period boundary
//  update_pending out 1               shadow holds values not yet applied
// BEHAVIOUR
//  Reset (async, reset=0): cnt=1, dir=up, active P=0, active D[*]=0, active centre=0,
//   pending flag=0, out=0, period_end=0, update_pending=0.
//  Edge mode: cnt runs 1,2..P, then wraps to 1. Boundary is the cycle with cnt==P.
//  Centre mode: cnt runs 1..P up, then P..1 down (both ends held 2 cycles), giving 2P cycles.
//   Boundary is the cycle with dir=down and cnt==1.
//  Compare: raw[i] = (cnt <= D[i]); out[i] <= polarity[i] ? raw[i] : ~raw[i].
//   Output latency is 1 clk after cnt.
//  Duty limits: D=0 gives constant inactive. D>=P gives constant active.
//   Centre mode high time = 2*min(D,P) cycles.
//  P=0 (also the post-reset state): cnt held at 1, dir=up, out=inactive level, no period_end.
//   An update_req while P=0 applies on the next clk.
//  Shadow registers:
//   - update_req=1 copies period, duty and centre into shadow and sets the pending flag.
//   - At a boundary with pending=1: active <= shadow, pending cleared, cnt restarts at 1 (dir=up).
//   - Boundary and update_req in the same cycle: the new values go to shadow and apply at
//     the NEXT boundary. The previously pending shadow is overwritten, not applied.
//   - Back-to-back update_req: last one wins.
//  period_end: registered, asserted the cycle after the boundary cycle.
//  enable=0:
//   - cnt reset to 1, dir=up, out=inactive, period_end=0.
//   - Pending shadow applies immediately (next clk).
//   - On re-enable, the first cycle has cnt=1.
//  Mode change via shadow only; a live centre input change without update_req has no effect.
//  Reset mid-period: all state cleared at once; the shadow is lost.
//  Arithmetic: all compares unsigned WIDTH-bit; cnt never exceeds P, so no wrap past 2^WIDTH-1.
//  polarity is not shadowed: it applies on the next clk.
// STRUCTURE
//  Package pwm_pkg:
//   - PWM_EDGE/PWM_CENTRE mode constants
//   - dir_t enum {DIR_UP, DIR_DOWN}
//   - default WIDTH/CHANNELS localparams
//  Top holds: counter + direction FSM, shadow/active registers, pending flag, period_end.
//  Sub-module pwm_channel_cmp (WIDTH):
//   - inputs: cnt, active duty, polarity, run
//   - registered out bit
//   - instantiated CHANNELS times via generate
// TESTING
//  1. Edge mode: update P=10, D={0,3,10,15}, polarity=4'hF, enable.
//     Out pattern per 10 cycles: ch0 always 0, ch1 high 3, ch2 always 1, ch3 always 1.
//     period_end pulses every 10 clk.
//  2. Centre mode: P=8, D[0]=2, polarity[0]=1.
//     Out high 4 of 16 cycles, centred on cnt=1 at the boundary.
//     period_end pulses every 16 clk.
//  3. Shadow: running at P=10, D=5. Issue update D=7 at cnt=4.
//     Out keeps 5 high through the current period; next period 7 high.
//     update_pending is 1 until the boundary.
//  4. Collision: update_req in the boundary cycle (cnt==P), then a second update_req 2 clk later.
//     Only the second set applies, at the following boundary.
//  5. Polarity: D[1]=3, P=10. Toggle polarity[1] to 0 mid-period.
//     out[1] inverts on the next clk; duty timing is unchanged.
//  6. Reset/enable:
//     - Assert reset at cnt=6: all outputs 0 immediately.
//     - After release with P=0: outputs inactive, no period_end.
//     - enable=0 mid-run: cnt back to 1 and out inactive within 1 clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_DEF_WIDTH    = 9;
    localparam int unsigned PWM_DEF_CHANNELS = 4;

    // Counting mode, as captured in the shadow/active centre bit
    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTRE = 1'b1;

    // Counter direction; only centre-aligned mode ever counts down
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM compare channel: registered (cnt <= duty) with polarity, inactive level when stopped.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             polarity,
    input  logic             run,
    output logic             out
);

    logic raw_c;

    // Raw compare against the active duty
    always_comb begin
        raw_c = (cnt <= duty);
    end

    // Output flop: polarity applied live; inactive level is the inverse of polarity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= 1'b0;
        end else if (run) begin
            out <= polarity ? raw_c : ~raw_c;
        end else begin
            out <= ~polarity;
        end
    end

endmodule

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM: shared edge/centre-aligned counter, double-buffered period/duty/mode.
module pwm_multi_core
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = PWM_DEF_WIDTH,
    parameter int unsigned CHANNELS = PWM_DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      update_req,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      centre,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       out,
    output logic                      period_end,
    output logic                      update_pending
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    dir_t                      dir_q, dir_d;
    logic [WIDTH-1:0]          period_act_q, period_sh_q;
    logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_sh_q;
    logic                      centre_act_q, centre_sh_q;
    logic                      pending_q;
    logic                      run_c, boundary_c, apply_sh_c;

    // Counter/direction state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_ONE;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Next count: restart at 1 when stopped or at a boundary, else step per mode
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!run_c || boundary_c) begin
            cnt_d = CNT_ONE;
            dir_d = DIR_UP;
        end else if (centre_act_q == PWM_CENTRE) begin
            if (dir_q == DIR_UP) begin
                if (cnt_q == period_act_q) begin
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Decodes: running, period boundary, and when the shadow may be applied
    always_comb begin
        run_c      = enable && (period_act_q != '0);
        boundary_c = 1'b0;
        if (run_c) begin
            if (centre_act_q == PWM_CENTRE) begin
                boundary_c = (dir_q == DIR_DOWN) && (cnt_q == CNT_ONE);
            end else begin
                boundary_c = (cnt_q == period_act_q);
            end
        end
        // A same-cycle update_req overwrites the shadow instead of letting it apply
        apply_sh_c = pending_q && !update_req && (boundary_c || !run_c);
    end

    // Shadow capture and active-set transfer; while stopped an update goes straight to active
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_sh_q  <= '0;
            duty_sh_q    <= '0;
            centre_sh_q  <= PWM_EDGE;
            period_act_q <= '0;
            duty_act_q   <= '0;
            centre_act_q <= PWM_EDGE;
            pending_q    <= 1'b0;
        end else begin
            if (update_req) begin
                period_sh_q <= period;
                duty_sh_q   <= duty;
                centre_sh_q <= centre;
            end
            if (update_req && !run_c) begin
                period_act_q <= period;
                duty_act_q   <= duty;
                centre_act_q <= centre;
                pending_q    <= 1'b0;
            end else if (update_req) begin
                pending_q <= 1'b1;
            end else if (apply_sh_c) begin
                period_act_q <= period_sh_q;
                duty_act_q   <= duty_sh_q;
                centre_act_q <= centre_sh_q;
                pending_q    <= 1'b0;
            end
        end
    end

    // Period-end pulse, one cycle after the boundary cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_end <= 1'b0;
        end else begin
            period_end <= boundary_c;
        end
    end

    assign update_pending = pending_q;

    // Per-channel compare outputs
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk      (clk),
            .reset    (reset),
            .cnt      (cnt_q),
            .duty     (duty_act_q[i*WIDTH +: WIDTH]),
            .polarity (polarity[i]),
            .run      (run_c),
            .out      (out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_core.sv
// Scoreboard bench for pwm_multi_core: stimulus pushes cycle-stamped expectations, monitor checks.
module tb_pwm_multi_core;

    localparam int unsigned W = 9;
    localparam int unsigned N = 4;
    localparam int NEVER = 99999;

    logic           clk;
    logic           reset;
    logic           enable;
    logic           update_req;
    logic [W-1:0]   period;
    logic [N*W-1:0] duty;
    logic           centre;
    logic [N-1:0]   polarity;
    logic [N-1:0]   out;
    logic           period_end;
    logic           update_pending;

    pwm_multi_core #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .update_req     (update_req),
        .period         (period),
        .duty           (duty),
        .centre         (centre),
        .polarity       (polarity),
        .out            (out),
        .period_end     (period_end),
        .update_pending (update_pending)
    );

    typedef struct {
        int         cyc;
        logic [3:0] out;
        logic       pe;
        logic       pend;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp = n_cmp + 1;
            if (mon_e.cyc != cyc || out !== mon_e.out || period_end !== mon_e.pe
                || update_pending !== mon_e.pend) begin
                n_bad = n_bad + 1;
                $display("FAIL %s cyc=%0d (stamp %0d): out=%b want %b, period_end=%b want %b, update_pending=%b want %b",
                         mon_e.name, cyc, mon_e.cyc, out, mon_e.out, period_end, mon_e.pe,
                         update_pending, mon_e.pend);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Counter value in the j-th running cycle (j starts at 1)
    function automatic int cnt_at(input int j, input int p, input bit ctr);
        int k;
        if (!ctr) return ((j - 1) % p) + 1;
        k = (j - 1) % (2 * p);
        return (k < p) ? k + 1 : 2 * p - k;
    endfunction

    function automatic logic [3:0] pwm_exp(input int c, input logic [35:0] d, input logic [3:0] pol);
        logic [3:0] r;
        logic       raw;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            raw  = (c <= int'(d[i*9 +: 9]));
            r[i] = pol[i] ? raw : ~raw;
        end
        return r;
    endfunction

    task automatic push(input int c, input logic [3:0] o, input logic pe, input logic pd, input string nm);
        exp_t e;
        e.cyc  = c;
        e.out  = o;
        e.pe   = pe;
        e.pend = pd;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Expected outputs for cycles s+m_lo..s+m_hi, where s+1 is the first running cycle (cnt=1)
    task automatic push_window(input int s, input int m_lo, input int m_hi, input int p, input bit ctr,
                               input logic [35:0] da, input logic [35:0] db, input int j_sw,
                               input logic [3:0] pa, input logic [3:0] pb, input int jp_sw,
                               input int pend_lo, input int pend_hi, input string nm);
        int         j;
        int         c;
        logic [3:0] o;
        logic       pe;
        logic       pd;
        for (int m = m_lo; m <= m_hi; m++) begin
            pd = (m >= pend_lo) && (m <= pend_hi);
            if (m == 1) begin
                o  = ~pa;
                pe = 1'b0;
            end else begin
                j  = m - 1;
                c  = cnt_at(j, p, ctr);
                o  = pwm_exp(c, (j >= j_sw) ? db : da, (j >= jp_sw) ? pb : pa);
                pe = ctr ? ((j % (2 * p)) == 0) : (c == p);
            end
            push(s + m, o, pe, pd, nm);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) next();
    endtask

    task automatic load(input int p, input logic [35:0] d, input bit ctr, input logic [3:0] pol, input bit en);
        enable     = en;
        update_req = 1'b1;
        period     = W'(p);
        duty       = d;
        centre     = ctr;
        polarity   = pol;
    endtask

    task automatic go();
        next();
        update_req = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic upd(input logic [35:0] d);
        update_req = 1'b1;
        duty       = d;
        next();
        update_req = 1'b0;
    endtask

    logic [35:0] d_edge, d_ctr, d_a, d_b, d_c, d_x, d_pol, e1, e2, d_rst, d_byp;
    int s;

    initial begin
        d_edge = {9'd15, 9'd10, 9'd3, 9'd0};
        d_ctr  = {9'd0, 9'd0, 9'd0, 9'd2};
        d_a    = {9'd0, 9'd0, 9'd0, 9'd5};
        d_b    = {9'd0, 9'd0, 9'd0, 9'd7};
        d_x    = {9'd0, 9'd0, 9'd0, 9'd1};
        d_c    = {9'd0, 9'd0, 9'd0, 9'd8};
        d_pol  = {9'd0, 9'd0, 9'd3, 9'd0};
        e1     = {9'd0, 9'd3, 9'd10, 9'd5};
        e2     = {9'd0, 9'd3, 9'd10, 9'd1};
        d_rst  = {9'd0, 9'd10, 9'd0, 9'd0};
        d_byp  = {9'd0, 9'd0, 9'd0, 9'd2};

        reset = 1'b0; enable = 1'b0; update_req = 1'b0;
        period = '0; duty = '0; centre = 1'b0; polarity = 4'hF;

        // Reset state, then idle with P=0
        for (int c = 1; c <= 6; c++) push(c, 4'b0000, 1'b0, 1'b0, "reset");
        run_to(3);
        reset = 1'b1;
        run_to(6);

        // Edge mode P=10, duties 0/3/10/15
        s = cyc;
        load(10, d_edge, 1'b0, 4'hF, 1'b0);
        push_window(s, 1, 31, 10, 1'b0, d_edge, d_edge, NEVER, 4'hF, 4'hF, NEVER, 1, 0, "edge");
        go();
        run_to(s + 31);

        // Centre mode P=8, D0=2
        s = cyc;
        load(8, d_ctr, 1'b1, 4'hF, 1'b0);
        push_window(s, 1, 33, 8, 1'b1, d_ctr, d_ctr, NEVER, 4'hF, 4'hF, NEVER, 1, 0, "centre");
        go();
        run_to(s + 33);

        // Shadow: D 5 -> 7 requested at cnt=4, applies at next boundary
        s = cyc;
        load(10, d_a, 1'b0, 4'hF, 1'b0);
        push_window(s, 1, 25, 10, 1'b0, d_a, d_b, 11, 4'hF, 4'hF, NEVER, 5, 10, "shadow");
        go();
        run_to(s + 4);
        upd(d_b);
        run_to(s + 25);

        // Collision: pending X overwritten by B at the boundary, then C wins
        s = cyc;
        load(10, d_a, 1'b0, 4'hF, 1'b0);
        push_window(s, 1, 35, 10, 1'b0, d_a, d_c, 21, 4'hF, 4'hF, NEVER, 6, 20, "collide");
        go();
        run_to(s + 5);
        upd(d_x);
        run_to(s + 10);
        upd({9'd0, 9'd0, 9'd0, 9'd2});
        run_to(s + 12);
        upd(d_c);
        run_to(s + 35);

        // Live polarity change on channel 1 at cnt=5
        s = cyc;
        load(10, d_pol, 1'b0, 4'hF, 1'b0);
        push_window(s, 1, 30, 10, 1'b0, d_pol, d_pol, NEVER, 4'hF, 4'b1101, 15, 1, 0, "polarity");
        go();
        run_to(s + 15);
        polarity = 4'b1101;
        run_to(s + 30);

        // Disable mid-run with a pending update; re-enable restarts at cnt=1 with new duties
        s = cyc;
        load(10, e1, 1'b0, 4'b0101, 1'b0);
        push_window(s, 1, 6, 10, 1'b0, e1, e1, NEVER, 4'b0101, 4'b0101, NEVER, 4, 6, "disable");
        push(s + 7, 4'b1010, 1'b0, 1'b0, "disable");
        push_window(s + 7, 1, 15, 10, 1'b0, e2, e2, NEVER, 4'b0101, 4'b0101, NEVER, 1, 0, "reenable");
        go();
        run_to(s + 3);
        upd(e2);
        run_to(s + 6);
        enable = 1'b0;
        run_to(s + 8);
        enable = 1'b1;
        run_to(s + 22);

        // Async reset at cnt=6 with a pending update; afterwards P=0 keeps everything idle
        s = cyc;
        load(10, d_rst, 1'b0, 4'hF, 1'b0);
        push_window(s, 1, 5, 10, 1'b0, d_rst, d_rst, NEVER, 4'hF, 4'hF, NEVER, 4, 5, "rst_pre");
        for (int c = 6; c <= 8; c++) push(s + c, 4'b0000, 1'b0, 1'b0, "rst_mid");
        for (int c = 9; c <= 20; c++) push(s + c, 4'b0000, 1'b0, 1'b0, "p_zero");
        go();
        run_to(s + 3);
        upd({9'd0, 9'd0, 9'd0, 9'd7});
        run_to(s + 6);
        reset = 1'b0;
        run_to(s + 8);
        reset = 1'b1;
        run_to(s + 20);

        // Update while enabled with P=0 takes effect on the next clock
        s = cyc;
        load(4, d_byp, 1'b0, 4'hF, 1'b1);
        push_window(s, 1, 13, 4, 1'b0, d_byp, d_byp, NEVER, 4'hF, 4'hF, NEVER, 1, 0, "bypass");
        go();
        run_to(s + 13);

        next();
        next();
        if (sb.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
